// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: critical-word-first line refill and store arbitration for the data RAM write port
module cache_refill_ctrl #(
  parameter int LEN_DATA = 32,
  parameter int LEN_INDEX = 7,
  parameter int LINE_WORDS_LOG2 = 3,
  localparam int LEN_ADDR = LEN_INDEX + LINE_WORDS_LOG2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       miss_req,
  input  logic [LEN_INDEX-1:0]       miss_index,
  input  logic [LINE_WORDS_LOG2-1:0] miss_word,
  output logic                       busy,
  output logic                       refill_done,
  output logic                       crit_valid,
  output logic [LEN_DATA-1:0]        crit_data,
  output logic                       rd_req,
  output logic [LEN_INDEX-1:0]       rd_index,
  output logic [LINE_WORDS_LOG2-1:0] rd_word,
  input  logic                       rd_gnt,
  input  logic                       rvalid,
  input  logic [LEN_DATA-1:0]        rdata,
  input  logic                       st_req,
  input  logic [LEN_ADDR-1:0]        st_addr,
  input  logic [LEN_DATA/8-1:0]      st_wstrb,
  input  logic [LEN_DATA-1:0]        st_data,
  output logic                       st_ack,
  output logic                       ram_ena,
  output logic [LEN_DATA/8-1:0]      ram_wea,
  output logic [LEN_ADDR-1:0]        ram_addra,
  output logic [LEN_DATA-1:0]        ram_dina
);
  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;
  state_t state;
  logic [LINE_WORDS_LOG2-1:0] cnt, word_q, woff;
  logic [LEN_INDEX-1:0] idx_q;
  logic beat;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      word_q <= '0;
    end else begin
      case (state)
        IDLE: if (miss_req) begin
          idx_q <= miss_index;
          word_q <= miss_word;
          cnt <= '0;
          state <= REQ;
        end
        REQ: if (rd_gnt) state <= RECV;
        RECV: if (rvalid) begin
          cnt <= cnt + 1'b1;
          if (&cnt) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // everything below is gated by resetn so the port reads idle while reset is held
  always_comb begin
    beat = resetn && state == RECV && rvalid;
    woff = word_q + cnt;
    busy = resetn && state != IDLE;
    refill_done = resetn && state == DONE;
    rd_req = resetn && state == REQ;
    rd_index = idx_q;
    rd_word = word_q;
    crit_valid = beat && cnt == '0;
    crit_data = rdata;
    st_ack = resetn && st_req && !beat && !(busy && st_addr[LEN_ADDR-1 -: LEN_INDEX] == idx_q);
    ram_ena = beat || st_ack;
    ram_wea = beat ? '1 : st_ack ? st_wstrb : '0;
    ram_addra = beat ? {idx_q, woff} : st_addr;
    ram_dina = beat ? rdata : st_data;
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed refill, bubble, store-conflict and reset scenarios with a byte-lane RAM model
module tb_cache_refill_ctrl;
  logic clk = 0;
  always #5 clk = ~clk;
  logic resetn, miss_req, busy, refill_done, crit_valid, rd_req, rd_gnt, rvalid, st_req, st_ack, ram_ena;
  logic [6:0] miss_index, rd_index;
  logic [2:0] miss_word, rd_word;
  logic [31:0] crit_data, rdata, st_data, ram_dina;
  logic [9:0] st_addr, ram_addra;
  logic [3:0] st_wstrb, ram_wea;
  int n_cmp = 0, n_bad = 0, wr_cnt = 0, base = 0;
  logic [31:0] mem [0:1023];
  logic [2:0] ord1 [8] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

  cache_refill_ctrl dut (
    .clk(clk), .resetn(resetn), .miss_req(miss_req), .miss_index(miss_index), .miss_word(miss_word),
    .busy(busy), .refill_done(refill_done), .crit_valid(crit_valid), .crit_data(crit_data),
    .rd_req(rd_req), .rd_index(rd_index), .rd_word(rd_word), .rd_gnt(rd_gnt), .rvalid(rvalid),
    .rdata(rdata), .st_req(st_req), .st_addr(st_addr), .st_wstrb(st_wstrb), .st_data(st_data),
    .st_ack(st_ack), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina)
  );

  always @(posedge clk) if (ram_ena) begin
    wr_cnt <= wr_cnt + 1;
    for (int b = 0; b < 4; b++) if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    resetn = 0; miss_req = 0; miss_index = 0; miss_word = 0; rd_gnt = 0; rvalid = 0; rdata = 0;
    st_req = 1; st_addr = '0; st_wstrb = 4'hF; st_data = 32'hDEAD_BEEF;
    cyc; cyc; #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_st_ack", st_ack, 0);
    chk("rst_ram_ena", ram_ena, 0);
    chk("rst_ram_wea", ram_wea, 0);
    chk("rst_done", refill_done, 0);
    chk("rst_crit", crit_valid, 0);
    // basic refill, index 0x15, critical word 5, immediate grant
    cyc; resetn = 1; st_req = 0; miss_req = 1; miss_index = 7'h15; miss_word = 3'd5; base = wr_cnt; #1;
    chk("t1_idle_rd_req", rd_req, 0);
    cyc; rd_gnt = 1; #1;
    chk("t1_rd_req", rd_req, 1);
    chk("t1_rd_index", rd_index, 7'h15);
    chk("t1_rd_word", rd_word, 3'd5);
    for (int k = 0; k < 8; k++) begin
      cyc; rd_gnt = 0; rvalid = 1; rdata = 32'hA000_0000 + k; #1;
      chk("t1_addr", ram_addra, {7'h15, ord1[k]});
      chk("t1_wea", ram_wea, 4'hF);
      chk("t1_dina", ram_dina, 32'hA000_0000 + k);
      chk("t1_crit", crit_valid, k == 0);
      if (k == 0) chk("t1_crit_data", crit_data, 32'hA000_0000);
    end
    cyc; rvalid = 0; #1;
    chk("t1_done", refill_done, 1);
    chk("t1_done_no_write", ram_ena, 0);
    miss_req = 0;
    cyc; #1;
    chk("t1_idle", busy, 0);
    chk("t1_done_pulse", refill_done, 0);
    cyc; #1;
    chk("t1_no_retrigger", busy, 0);
    chk("t1_writes", wr_cnt - base, 8);
    chk("t1_mem_w5", mem[{7'h15, 3'd5}], 32'hA000_0000);
    chk("t1_mem_w4", mem[{7'h15, 3'd4}], 32'hA000_0007);
    // delayed grant and two-cycle beat gaps, index 2 word 3
    cyc; miss_req = 1; miss_index = 7'h02; miss_word = 3'd3; base = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      cyc; miss_index = 7'h7F; miss_word = 3'd0; #1;
      chk("t2_rd_req", rd_req, 1);
      chk("t2_rd_index", rd_index, 7'h02);
      chk("t2_rd_word", rd_word, 3'd3);
    end
    cyc; rd_gnt = 1; #1;
    chk("t2_rd_req_gnt", rd_req, 1);
    for (int k = 0; k < 8; k++) begin
      repeat (2) begin
        cyc; rd_gnt = 0; rvalid = 0; #1;
        chk("t2_gap", ram_ena, 0);
      end
      cyc; rvalid = 1; rdata = 32'hB000_0000 + k; #1;
      chk("t2_addr", ram_addra, {7'h02, 3'(3 + k)});
    end
    cyc; rvalid = 0; #1;
    chk("t2_done", refill_done, 1);
    miss_req = 0;
    cyc; #1;
    chk("t2_writes", wr_cnt - base, 8);
    chk("t2_idle", busy, 0);
    // store traffic during a refill of index 3, critical word 0
    cyc; miss_req = 1; miss_index = 7'd3; miss_word = 3'd0; base = wr_cnt;
    cyc; rd_gnt = 1; #1;
    chk("t3_rd_req", rd_req, 1);
    cyc; rd_gnt = 0; rvalid = 1; rdata = 32'hC000_0000;
    st_req = 1; st_addr = {7'd9, 3'd1}; st_wstrb = 4'b0101; st_data = 32'h1122_3344; #1;
    chk("t3_beat_blocks_store", st_ack, 0);
    chk("t3_beat_addr", ram_addra, {7'd3, 3'd0});
    chk("t3_crit", crit_valid, 1);
    cyc; rvalid = 0; #1;
    chk("t3_other_ack", st_ack, 1);
    chk("t3_other_addr", ram_addra, {7'd9, 3'd1});
    chk("t3_other_wea", ram_wea, 4'b0101);
    cyc; st_addr = {7'd3, 3'd2}; rvalid = 1; rdata = 32'hC000_0001; #1;
    chk("t3_beat1_ack", st_ack, 0);
    chk("t3_beat1_addr", ram_addra, {7'd3, 3'd1});
    for (int k = 2; k < 8; k++) begin
      cyc; rvalid = 0; #1;
      chk("t3_same_line_stall", st_ack, 0);
      chk("t3_stall_no_write", ram_ena, 0);
      cyc; rvalid = 1; rdata = 32'hC000_0000 + k; #1;
      chk("t3_addr", ram_addra, {7'd3, 3'(k)});
    end
    cyc; rvalid = 0; #1;
    chk("t3_done", refill_done, 1);
    chk("t3_done_stall", st_ack, 0);
    miss_req = 0;
    cyc; #1;
    chk("t3_idle", busy, 0);
    chk("t3_same_ack", st_ack, 1);
    chk("t3_same_addr", ram_addra, {7'd3, 3'd2});
    chk("t3_same_wea", ram_wea, 4'b0101);
    cyc; st_req = 0; #1;
    chk("t3_mem_merge", mem[{7'd3, 3'd2}], 32'hC022_0044);
    chk("t3_mem_other", mem[{7'd9, 3'd1}], 32'h0022_0044);
    chk("t3_mem_w7", mem[{7'd3, 3'd7}], 32'hC000_0007);
    chk("t3_writes", wr_cnt - base, 10);
    // reset after five beats, then a clean refill of the same line
    cyc; miss_req = 1; miss_index = 7'h11; miss_word = 3'd6; base = wr_cnt;
    cyc; rd_gnt = 1;
    for (int k = 0; k < 5; k++) begin
      cyc; rd_gnt = 0; rvalid = 1; rdata = 32'hE000_0000 + k; #1;
      chk("t4_addr", ram_addra, {7'h11, 3'(6 + k)});
    end
    cyc; resetn = 0; miss_req = 0; rdata = 32'hEEEE_EEEE; #1;
    chk("t4_rst_ram_ena", ram_ena, 0);
    cyc; resetn = 1; #1;
    chk("t4_busy", busy, 0);
    chk("t4_rd_req", rd_req, 0);
    chk("t4_ram_ena", ram_ena, 0);
    chk("t4_crit", crit_valid, 0);
    chk("t4_done", refill_done, 0);
    cyc; #1;
    chk("t4_ignored_beat", ram_ena, 0);
    chk("t4_writes", wr_cnt - base, 5);
    cyc; rvalid = 0; miss_req = 1;
    cyc; rd_gnt = 1; #1;
    chk("t4_rd_req_again", rd_req, 1);
    for (int k = 0; k < 8; k++) begin
      cyc; rd_gnt = 0; rvalid = 1; rdata = 32'hF000_0000 + k; #1;
      chk("t4_addr2", ram_addra, {7'h11, 3'(6 + k)});
    end
    cyc; rvalid = 0; #1;
    chk("t4_done2", refill_done, 1);
    chk("t4_writes2", wr_cnt - base, 13);
    miss_req = 0;
    cyc;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Sequences port A (write port) of a cache data block RAM (`LEN_DATA` wide, `LEN_INDEX+LINE_WORDS_LOG2` address bits, per-byte write enables).
- Runs a critical-word-first wrap refill of one cache line from the memory bus into the RAM.
- Shares the same write port with CPU store hits; refill beats take priority.
- Sits between the cache miss logic, the bus read interface and the data RAM.

Parameters:
- `LEN_DATA`, 32, data/beat width in bits (multiple of 8).
- `LEN_INDEX`, 7, set-index bits.
- `LINE_WORDS_LOG2`, 3, log2 of words per line (8 words).
- `LEN_ADDR`, `LEN_INDEX+LINE_WORDS_LOG2`, RAM word-address width (derived, not overridden).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `miss_req` in 1: refill request, level, held until `refill_done`.
- `miss_index` in `LEN_INDEX`: line index to refill.
- `miss_word` in `LINE_WORDS_LOG2`: critical word offset.
- `busy` out 1: high in REQ/RECV/DONE.
- `refill_done` out 1: one-cycle pulse, line complete.
- `crit_valid` out 1: one-cycle pulse, critical word present on `crit_data`.
- `crit_data` out `LEN_DATA`: critical word (equals `rdata` of beat 0).
- `rd_req` out 1: bus read-burst request.
- `rd_index` out `LEN_INDEX`: burst line index.
- `rd_word` out `LINE_WORDS_LOG2`: burst start word.
- `rd_gnt` in 1: bus accepts request when `rd_req && rd_gnt`.
- `rvalid` in 1: read beat valid.
- `rdata` in `LEN_DATA`: read beat data.
- `st_req` in 1: store write request.
- `st_addr` in `LEN_ADDR`: store word address, {index, word}.
- `st_wstrb` in `LEN_DATA/8`: store byte enables.
- `st_data` in `LEN_DATA`: store data.
- `st_ack` out 1: store written this cycle.
- `ram_ena` out 1: RAM port A enable.
- `ram_wea` out `LEN_DATA/8`: RAM port A byte write enables.
- `ram_addra` out `LEN_ADDR`: RAM port A address.
- `ram_dina` out `LEN_DATA`: RAM port A write data.

Behaviour:
- Interface: one clock `clk`; reset `resetn` is synchronous, active-low.
- While `resetn`=0 (next edge): state goes to IDLE, beat counter to 0, latched index/word to 0.
  - All outputs read 0 during reset: `busy`, `refill_done`, `crit_valid`, `rd_req`, `st_ack`, `ram_ena`, `ram_wea`.
- FSM states: IDLE, REQ, RECV, DONE.
- IDLE:
  - Takes `miss_req`=1 → latch `miss_index`/`miss_word`, clear counter, go to REQ.
  - `rvalid` is ignored.
- REQ:
  - `rd_req`=1; `rd_index`/`rd_word` come from the latches and stay stable.
  - `rd_req && rd_gnt` → RECV next cycle; otherwise hold.
  - `rvalid` is ignored (bus never returns a beat in the grant cycle).
- RECV, on each `rvalid`=1 beat k (k = counter):
  - `ram_ena`=1, `ram_wea`=all ones, `ram_dina`=`rdata`.
  - `ram_addra`={latched index, (latched word + k) mod 2^`LINE_WORDS_LOG2`}, wrapping.
  - Counter increments.
  - k=0 → `crit_valid`=1 and `crit_data`=`rdata` in the same cycle.
  - k=2^`LINE_WORDS_LOG2`−1 → DONE next cycle.
  - Gaps with `rvalid`=0 hold state and counter.
- DONE: `refill_done`=1 for exactly one cycle, then IDLE.
  - `miss_req` is sampled again only in IDLE, so a held request does not retrigger before the requester drops it.
- Store path:
  - `st_ack` = `st_req` && !(RECV && `rvalid`) && !(`busy` && `st_addr` index == latched index).
  - Stores to the line being refilled stall until IDLE; other lines proceed during refill.
  - When `st_ack`=1: `ram_ena`=1, `ram_wea`=`st_wstrb`, `ram_addra`=`st_addr`, `ram_dina`=`st_data`.
  - The store requester holds inputs until acked.
- Port A outputs are combinational from state/inputs; the RAM commits on the same clock edge.
- No port-A activity → `ram_ena`=0, `ram_wea`=0.
- Latency:
  - `miss_req` at edge t → `rd_req` from cycle t+1.
  - With `rd_gnt` immediate and back-to-back beats, `refill_done` follows 2^`LINE_WORDS_LOG2` cycles after the first beat.
- Reset mid-refill: immediate return to IDLE; in-flight bus beats after reset are ignored. Discarding the burst is the bus side's responsibility.

Test Plan:
- Basic refill: index=0x15, word=5, `rd_gnt` same cycle, 8 back-to-back beats D0..D7 → RAM writes in word order 5,6,7,0,1,2,3,4 at addr {0x15,w}; `crit_valid` with D0 on first beat; `refill_done` one cycle after last beat; all writes have `wea`=4'hF.
- Delayed grant and bubbles: `rd_gnt` after 3 cycles, `rvalid` gaps of 2 cycles → `rd_req`/`rd_index`/`rd_word` stable for 3 cycles; exactly 8 writes; counter never skips.
- Store conflict: during refill of index 3, `st_req` to {3,2} and separately {9,1} with `wstrb`=4'b0101 → {9,1} acked only on non-`rvalid` cycles, with byte-masked write; {3,2} held until IDLE, then acked and overwrites bytes 0 and 2 of refilled data.
- Simultaneous `rvalid` and `st_req` to another index → refill beat written, `st_ack`=0; store acked the next non-beat cycle.
- Held `miss_req` → one refill only; after `miss_req` drops then rises with word=0 → second refill wraps 0..7.
- `resetn` low after beat 4 → next cycle IDLE, all outputs 0; following `rvalid` beats produce no RAM write; new miss runs a full 8 beats.
